// File: rtl/mult_ctrl.sv
// Sequencer for the shift-add multiplier: latches operands, steps it 32 times,
// captures the product into HI/LO and serves MFHI/MFLO. Define MULT_CTRL_SIGNED_EN to accept MULT.
module mult_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  funct,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [63:0] prodIn,
  output logic [5:0]  Signal,
  output logic [31:0] mulA,
  output logic [31:0] mulB,
  output logic        busy,
  output logic        done,
  output logic [31:0] dataOut
);

  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] SIG_MUL = 6'b011001;
  localparam logic [5:0] SIG_OUT = 6'b111111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [4:0]  cnt_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        accept_mul_s;
  logic [31:0] opa_s;
  logic [31:0] opb_s;
  logic        neg_s;
  logic [63:0] result_s;

`ifdef MULT_CTRL_SIGNED_EN
  localparam logic [5:0] F_MULT = 6'b011000;
  logic neg_r;

  // Two's-complement magnitude; 32'h80000000 maps to itself, which is the right unsigned magnitude.
  function automatic logic [31:0] magnitude(input logic [31:0] v);
    if (v[31]) begin
      magnitude = ~v + 32'd1;
    end else begin
      magnitude = v;
    end
  endfunction
`endif

  // Decode an accepted multiply command and prepare operands
  always_comb begin
    accept_mul_s = 1'b0;
    opa_s        = dataA;
    opb_s        = dataB;
    neg_s        = 1'b0;
    if ((state_r == IDLE) && start) begin
      if (funct == F_MULTU) begin
        accept_mul_s = 1'b1;
      end
`ifdef MULT_CTRL_SIGNED_EN
      else if (funct == F_MULT) begin
        accept_mul_s = 1'b1;
        opa_s        = magnitude(dataA);
        opb_s        = magnitude(dataB);
        neg_s        = dataA[31] ^ dataB[31];
      end
`endif
      else begin
        accept_mul_s = 1'b0;
      end
    end else begin
      accept_mul_s = 1'b0;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_mul_s) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == 5'd31) begin
          state_s = CAPTURE;
        end else begin
          state_s = RUN;
        end
      end
      CAPTURE: state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

`ifdef MULT_CTRL_SIGNED_EN
  assign result_s = neg_r ? (~prodIn + 64'd1) : prodIn;
`else
  assign result_s = prodIn;
`endif

  // State register, step counter and registered control outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 5'd0;
      Signal  <= SIG_OUT;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_s;
      Signal  <= (state_s == RUN) ? SIG_MUL : SIG_OUT;
      busy    <= (state_s != IDLE);
      done    <= (state_r == CAPTURE);
      if (state_r == RUN) begin
        cnt_r <= cnt_r + 5'd1;
      end else begin
        cnt_r <= 5'd0;
      end
    end
  end

  // Operand latches, held for the whole run
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mulA <= 32'd0;
      mulB <= 32'd0;
    end else if (accept_mul_s) begin
      mulA <= opa_s;
      mulB <= opb_s;
    end else begin
      mulA <= mulA;
      mulB <= mulB;
    end
  end

`ifdef MULT_CTRL_SIGNED_EN
  // Result sign remembered from the accepted command
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_r <= 1'b0;
    end else if (accept_mul_s) begin
      neg_r <= neg_s;
    end else begin
      neg_r <= neg_r;
    end
  end
`endif

  // HI/LO are written only on the capture edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (state_r == CAPTURE) begin
      hi_r <= result_s[63:32];
      lo_r <= result_s[31:0];
    end else begin
      hi_r <= hi_r;
      lo_r <= lo_r;
    end
  end

  // MFHI/MFLO read port, idle only
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dataOut <= 32'd0;
    end else if ((state_r == IDLE) && start) begin
      case (funct)
        F_MFHI:  dataOut <= hi_r;
        F_MFLO:  dataOut <= lo_r;
        default: dataOut <= dataOut;
      endcase
    end else begin
      dataOut <= dataOut;
    end
  end

endmodule
